// File: rtl/sequenciador_busca.sv
// Fetch/issue sequencer: reads program words from a small synchronous memory,
// feeds them to a multi-cycle processor over DIN/Run and waits for Done with a watchdog.
module sequenciador_busca #(
  parameter int TIMEOUT = 8
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Enable,
  input  logic [15:0] MemData,
  input  logic        Done,
  output logic [4:0]  Addr,
  output logic [15:0] DIN,
  output logic        Run,
  output logic        Halt,
  output logic        Erro,
  output logic [7:0]  InstrCount
);

  localparam int WD_W = $clog2(TIMEOUT + 2);
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [3:0] {
    IDLE,
    BUSCA_I,
    LATCH_I,
    BUSCA_D,
    LATCH_D,
    EXEC,
    ESPERA,
    PAUSA,
    PARADO
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        pc_q, pc_d;
  logic [15:0]       din_q, din_d;
  logic              erro_q, erro_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [8:0]        ir_q, ir_d;
  logic [15:0]       imm_q, imm_d;

  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state_q <= IDLE;
      pc_q    <= '0;
      din_q   <= '0;
      erro_q  <= 1'b0;
      cnt_q   <= '0;
      wd_q    <= '0;
      ir_q    <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      din_q   <= din_d;
      erro_q  <= erro_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    din_d   = din_q;
    erro_d  = erro_q;
    cnt_d   = cnt_q;
    wd_d    = '0;
    ir_d    = ir_q;
    imm_d   = imm_q;
    case (state_q)
      IDLE: begin
        if (Enable) state_d = BUSCA_I;
      end
      BUSCA_I: state_d = LATCH_I;
      LATCH_I: begin
        ir_d = MemData[8:0];
        if (MemData[8:6] == OP_HALT) begin
          state_d = PARADO;
        end else if (MemData[8:6] == OP_MVI) begin
          pc_d    = pc_q + 5'd1;
          state_d = BUSCA_D;
        end else begin
          // DIN is registered, so the word must be loaded on the way into EXEC
          din_d   = {7'b0, MemData[8:0]};
          state_d = EXEC;
        end
      end
      BUSCA_D: state_d = LATCH_D;
      LATCH_D: begin
        imm_d   = MemData;
        din_d   = {7'b0, ir_q};
        state_d = EXEC;
      end
      EXEC: begin
        // EXEC is watchdog cycle 1, so the first ESPERA cycle is cycle 2
        wd_d    = WD_W'(2);
        din_d   = (ir_q[8:6] == OP_MVI) ? imm_q : {7'b0, ir_q};
        state_d = ESPERA;
      end
      ESPERA: begin
        if (Done) begin
          pc_d    = pc_q + 5'd1;
          cnt_d   = cnt_q + 8'd1;
          state_d = PAUSA;
        end else if (wd_q >= WD_W'(TIMEOUT)) begin
          erro_d  = 1'b1;
          state_d = PARADO;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      PAUSA: state_d = Enable ? BUSCA_I : IDLE;
      PARADO: state_d = PARADO;
      default: state_d = IDLE;
    endcase
  end

  assign Addr       = pc_q;
  assign DIN        = din_q;
  assign Run        = (state_q == EXEC) || (state_q == ESPERA);
  assign Halt       = (state_q == PARADO);
  assign Erro       = erro_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_sequenciador_busca.sv
// Bench for sequenciador_busca: directed scenarios plus a randomized program
// checked against an instruction-level model of the fetch/issue sequence.
module tb_sequenciador_busca;
  localparam int TIMEOUT = 8;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b1;
  logic        Enable = 1'b0;
  logic        Done = 1'b0;
  logic [15:0] MemData = 16'h0000;
  logic [4:0]  Addr;
  logic [15:0] DIN;
  logic        Run, Halt, Erro;
  logic [7:0]  InstrCount;

  logic [15:0] mem [32];
  int vectors = 0;
  int miscompares = 0;

  sequenciador_busca #(.TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Resetn(Resetn), .Enable(Enable), .MemData(MemData), .Done(Done),
    .Addr(Addr), .DIN(DIN), .Run(Run), .Halt(Halt), .Erro(Erro), .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) MemData <= mem[Addr];

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_reset;
    Resetn = 1'b1; Enable = 1'b0; Done = 1'b0;
    tick; tick;
    Resetn = 1'b0;
  endtask

  task automatic wait_run(output bit ok);
    int k = 0;
    while (Run !== 1'b1 && k < 12) begin tick; k++; end
    ok = (Run === 1'b1);
  endtask

  function automatic logic [15:0] rand_plain();
    logic [15:0] w;
    logic [2:0]  op;
    op = 3'($urandom_range(0, 5));
    if (op != 3'd0) op = op + 3'd1;
    w = 16'($urandom);
    w[8:6] = op;
    return w;
  endfunction

  function automatic logic [15:0] rand_mvi();
    logic [15:0] w;
    w = 16'($urandom);
    w[8:6] = 3'b001;
    return w;
  endfunction

  task automatic test_reset;
    Resetn = 1'b1; Enable = 1'($urandom); Done = 1'($urandom);
    tick; tick;
    vectors++;
    if ({Run, Halt, Erro} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags: run/halt/erro=%b want 000", {Run, Halt, Erro});
    end
    vectors++;
    if (Addr !== 5'd0 || DIN !== 16'h0 || InstrCount !== 8'd0) begin
      miscompares++; $display("FAIL reset_regs: addr=%0d din=%h cnt=%0d want 0 0000 0", Addr, DIN, InstrCount);
    end
    Resetn = 1'b0; Enable = 1'b0; Done = 1'b0;
    repeat (4) tick;
    vectors++;
    if (Run !== 1'b0 || Addr !== 5'd0) begin
      miscompares++; $display("FAIL idle_hold: run=%b addr=%0d want 0 0", Run, Addr);
    end
  endtask

  task automatic test_halt_basic;
    int run_cycles = 0;
    bit ok;
    for (int i = 0; i < 32; i++) mem[i] = 16'h01C0;
    mem[0] = 16'h0000;
    apply_reset;
    Enable = 1'b1;
    wait_run(ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL basic_run_rise: run=%b want 1", Run); end
    for (int k = 0; k < 12; k++) begin
      if (Run === 1'b1) run_cycles++;
      Done = (k == 1);
      tick;
    end
    Done = 1'b0;
    vectors++;
    if (run_cycles !== 2) begin miscompares++; $display("FAIL basic_run_len: got %0d want 2", run_cycles); end
    vectors++;
    if (Halt !== 1'b1 || InstrCount !== 8'd1 || Addr !== 5'd1 || Erro !== 1'b0 || Run !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_halt: halt=%b cnt=%0d addr=%0d erro=%b run=%b want 1 1 1 0 0", Halt, InstrCount, Addr, Erro, Run);
    end
  endtask

  task automatic test_mvi;
    bit ok;
    int k = 0;
    for (int i = 0; i < 32; i++) mem[i] = 16'h01C0;
    mem[0] = 16'h0048; mem[1] = 16'h1234; mem[2] = 16'h01C0;
    apply_reset;
    Enable = 1'b1;
    wait_run(ok);
    vectors++;
    if (ok !== 1'b1 || DIN !== 16'h0048 || Addr !== 5'd1) begin
      miscompares++; $display("FAIL mvi_exec: ok=%b din=%h addr=%0d want 1 0048 1", ok, DIN, Addr);
    end
    tick;
    vectors++;
    if (DIN !== 16'h1234 || Run !== 1'b1) begin
      miscompares++; $display("FAIL mvi_imm: din=%h run=%b want 1234 1", DIN, Run);
    end
    Done = 1'b1; tick; Done = 1'b0;
    vectors++;
    if (Addr !== 5'd2 || Run !== 1'b0 || InstrCount !== 8'd1) begin
      miscompares++; $display("FAIL mvi_done: addr=%0d run=%b cnt=%0d want 2 0 1", Addr, Run, InstrCount);
    end
    while (Halt !== 1'b1 && k < 12) begin tick; k++; end
    vectors++;
    if (Halt !== 1'b1 || Addr !== 5'd2 || DIN !== 16'h1234) begin
      miscompares++; $display("FAIL mvi_halt: halt=%b addr=%0d din=%h want 1 2 1234", Halt, Addr, DIN);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    for (int i = 0; i < 32; i++) mem[i] = rand_plain();
    apply_reset;
    Enable = 1'b1;
    wait_run(ok);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL wd_run_rise: run=%b want 1", Run); end
    for (int k = 1; k < TIMEOUT; k++) begin
      tick;
      vectors++;
      if ({Run, Halt, Erro} !== 3'b100) begin
        miscompares++; $display("FAIL wd_early k=%0d: run/halt/erro=%b want 100", k, {Run, Halt, Erro});
      end
    end
    tick;
    vectors++;
    if ({Run, Halt, Erro} !== 3'b011) begin
      miscompares++; $display("FAIL wd_expire: run/halt/erro=%b want 011", {Run, Halt, Erro});
    end
    Done = 1'b1; tick; Done = 1'b0;
    repeat (3) tick;
    vectors++;
    if ({Run, Halt, Erro} !== 3'b011 || Addr !== 5'd0 || InstrCount !== 8'd0) begin
      miscompares++;
      $display("FAIL wd_parado: run/halt/erro=%b addr=%0d cnt=%0d want 011 0 0", {Run, Halt, Erro}, Addr, InstrCount);
    end
    apply_reset;
    vectors++;
    if ({Run, Halt, Erro} !== 3'b000) begin
      miscompares++; $display("FAIL wd_reset_clear: run/halt/erro=%b want 000", {Run, Halt, Erro});
    end
    // Done arriving in the very cycle the watchdog expires must still succeed
    Enable = 1'b1;
    wait_run(ok);
    repeat (TIMEOUT - 1) tick;
    Done = 1'b1; tick; Done = 1'b0;
    vectors++;
    if ({Run, Halt, Erro} !== 3'b000 || InstrCount !== 8'd1 || Addr !== 5'd1) begin
      miscompares++;
      $display("FAIL wd_done_wins: run/halt/erro=%b cnt=%0d addr=%0d want 000 1 1", {Run, Halt, Erro}, InstrCount, Addr);
    end
  endtask

  task automatic test_random_program;
    int pc_m = 0;
    int cnt_m = 0;
    int exec_addr, d;
    logic [8:0]  ins;
    logic [15:0] din2;
    bit is_mvi, ok;
    for (int i = 0; i < 32; i++) mem[i] = rand_plain();
    mem[5] = rand_mvi();  mem[6] = 16'($urandom);
    mem[12] = rand_mvi(); mem[13] = 16'($urandom);
    mem[20] = rand_mvi(); mem[21] = 16'($urandom);
    mem[31] = rand_mvi();
    apply_reset;
    Enable = 1'b1;
    for (int n = 0; n < 40; n++) begin
      ins = mem[pc_m][8:0];
      is_mvi = (ins[8:6] == 3'b001);
      din2 = is_mvi ? mem[(pc_m + 1) % 32] : {7'b0, ins};
      exec_addr = is_mvi ? (pc_m + 1) % 32 : pc_m;
      pc_m = (pc_m + (is_mvi ? 2 : 1)) % 32;
      cnt_m = (cnt_m + 1) % 256;
      wait_run(ok);
      vectors++;
      if (ok !== 1'b1) begin
        miscompares++; $display("FAIL prog_run_rise n=%0d: run=%b want 1", n, Run);
        break;
      end
      vectors++;
      if (DIN !== {7'b0, ins} || Addr !== 5'(exec_addr)) begin
        miscompares++;
        $display("FAIL prog_exec n=%0d: din=%h addr=%0d want %h %0d", n, DIN, Addr, {7'b0, ins}, exec_addr);
      end
      Done = 1'($urandom_range(0, 1));
      d = $urandom_range(1, TIMEOUT - 1);
      for (int c = 1; c <= d; c++) begin
        tick;
        if (c == 1) begin
          vectors++;
          if (DIN !== din2 || Run !== 1'b1) begin
            miscompares++; $display("FAIL prog_espera n=%0d: din=%h run=%b want %h 1", n, DIN, Run, din2);
          end
        end
        Done = (c == d);
      end
      tick;
      vectors++;
      if (Addr !== 5'(pc_m) || InstrCount !== 8'(cnt_m) || Run !== 1'b0) begin
        miscompares++;
        $display("FAIL prog_done n=%0d: addr=%0d cnt=%0d run=%b want %0d %0d 0", n, Addr, InstrCount, Run, pc_m, cnt_m);
      end
      Done = 1'($urandom_range(0, 1));
      tick;
      Done = 1'b0;
    end
    vectors++;
    if (Halt !== 1'b0 || Erro !== 1'b0) begin
      miscompares++; $display("FAIL prog_flags: halt=%b erro=%b want 0 0", Halt, Erro);
    end
  endtask

  task automatic test_enable_drop;
    int runs = 0;
    bit ok;
    for (int i = 0; i < 32; i++) mem[i] = rand_plain();
    apply_reset;
    Enable = 1'b1;
    wait_run(ok);
    tick;
    Enable = 1'b0;
    tick;
    Done = 1'b1; tick; Done = 1'b0;
    vectors++;
    if (InstrCount !== 8'd1 || Run !== 1'b0 || Addr !== 5'd1) begin
      miscompares++; $display("FAIL en_complete: cnt=%0d run=%b addr=%0d want 1 0 1", InstrCount, Run, Addr);
    end
    for (int k = 0; k < 6; k++) begin tick; if (Run === 1'b1) runs++; end
    vectors++;
    if (runs !== 0 || Addr !== 5'd1 || Halt !== 1'b0) begin
      miscompares++; $display("FAIL en_parked: runs=%0d addr=%0d halt=%b want 0 1 0", runs, Addr, Halt);
    end
    Enable = 1'b1;
    wait_run(ok);
    vectors++;
    if (ok !== 1'b1 || DIN !== {7'b0, mem[1][8:0]}) begin
      miscompares++; $display("FAIL en_resume: ok=%b din=%h want 1 %h", ok, DIN, {7'b0, mem[1][8:0]});
    end
    Done = 1'b1; tick; tick; Done = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    for (int i = 0; i < 32; i++) mem[i] = rand_plain();
    apply_reset;
    Enable = 1'b1;
    wait_run(ok);
    tick; Done = 1'b1; tick; Done = 1'b0;
    wait_run(ok);
    tick;
    Resetn = 1'b1; Done = 1'b1;
    tick;
    Resetn = 1'b0; Done = 1'b0; Enable = 1'b0;
    vectors++;
    if (Run !== 1'b0 || Addr !== 5'd0 || InstrCount !== 8'd0 || DIN !== 16'h0 || {Halt, Erro} !== 2'b00) begin
      miscompares++;
      $display("FAIL rstmid_state: run=%b addr=%0d cnt=%0d din=%h halt/erro=%b want 0 0 0 0000 00",
               Run, Addr, InstrCount, DIN, {Halt, Erro});
    end
    Done = 1'b1; tick; Done = 1'b0;
    repeat (3) tick;
    vectors++;
    if (Run !== 1'b0 || Addr !== 5'd0 || InstrCount !== 8'd0) begin
      miscompares++; $display("FAIL rstmid_done_ignored: run=%b addr=%0d cnt=%0d want 0 0 0", Run, Addr, InstrCount);
    end
  endtask

  initial begin
    test_reset;
    test_halt_basic;
    test_mvi;
    test_timeout;
    test_random_program;
    test_enable_drop;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
